// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (FD, DE, EM, MW registers).
// Drives per-stage freeze and local_clr controls, detects load-use hazards,
// branch redirects, imem/dmem stalls and halt, and watchdogs dmem stalls.
// Optional feature: define HAZARD_PERF_CNT_EN to build the stall/flush counters;
// otherwise stall_cycles and flush_count are tied to 0.
module pipeline_hazard_ctrl #(
  parameter int unsigned DMEM_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             global_rst,
  input  logic [2:0]       rs_FD,
  input  logic             rs_valid_FD,
  input  logic [2:0]       rt_FD,
  input  logic             rt_valid_FD,
  input  logic [2:0]       write_reg_sel_DE,
  input  logic             reg_write_en_DE,
  input  logic             mem_read_DE,
  input  logic             branch_taken_EX,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  input  logic             dump_MW,
  output logic             freeze_PC,
  output logic             freeze_FD,
  output logic             freeze_DE,
  output logic             freeze_EM,
  output logic             clr_FD,
  output logic             clr_DE,
  output logic             clr_MW,
  output logic             halted,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned TW = (DMEM_TIMEOUT > 2) ? $clog2(DMEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TcntLast = TW'(DMEM_TIMEOUT - 1);

  typedef enum logic [1:0] {StRun, StMemWait, StHalted} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          squash_pend_q, squash_pend_d;
  logic          err_q, err_d;
  logic          lu;

  assign lu = mem_read_DE & reg_write_en_DE &
              ((rs_valid_FD & (rs_FD == write_reg_sel_DE)) |
               (rt_valid_FD & (rt_FD == write_reg_sel_DE)));

  assign halted          = (state_q == StHalted);
  assign mem_timeout_err = err_q;

  // Pipeline control outputs, priority-encoded from inputs and registered state.
  always_comb begin
    freeze_PC = 1'b0;
    freeze_FD = 1'b0;
    freeze_DE = 1'b0;
    freeze_EM = 1'b0;
    clr_FD    = 1'b0;
    clr_DE    = 1'b0;
    clr_MW    = 1'b0;
    if (global_rst) begin
      // keep every control quiet while reset is held
    end else if (state_q == StHalted) begin
      freeze_PC = 1'b1;
      freeze_FD = 1'b1;
      freeze_DE = 1'b1;
      freeze_EM = 1'b1;
    end else if (dmem_stall) begin
      // execute is frozen, so a coincident branch is re-presented later
      freeze_PC = 1'b1;
      freeze_FD = 1'b1;
      freeze_DE = 1'b1;
      freeze_EM = 1'b1;
      clr_MW    = 1'b1;
    end else if (branch_taken_EX) begin
      clr_FD = 1'b1;
      clr_DE = 1'b1;
    end else if (lu) begin
      freeze_PC = 1'b1;
      freeze_FD = 1'b1;
      clr_DE    = 1'b1;
    end else if (imem_stall || squash_pend_q) begin
      freeze_PC = 1'b1;
      clr_FD    = 1'b1;
    end
  end

  // Next-state: FSM, dmem watchdog and pending squash of a redirected fetch.
  always_comb begin
    state_d       = state_q;
    tcnt_d        = tcnt_q;
    err_d         = err_q;
    squash_pend_d = squash_pend_q;
    if (state_q != StHalted) begin
      if (dmem_stall) begin
        if (state_q == StRun) begin
          state_d = StMemWait;
          tcnt_d  = TW'(1);
        end else if (tcnt_q == TcntLast) begin
          err_d   = 1'b1;
          state_d = StHalted;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end else begin
        if (state_q == StMemWait) begin
          state_d = StRun;
          tcnt_d  = '0;
        end
        // the fetch outstanding at redirect time is dropped when it finally returns
        if (branch_taken_EX) begin
          squash_pend_d = imem_stall;
        end else if (!imem_stall && !lu) begin
          squash_pend_d = 1'b0;
        end
      end
      if (dump_MW) begin
        state_d = StHalted;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (global_rst) begin
      state_q       <= StRun;
      tcnt_q        <= '0;
      squash_pend_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      tcnt_q        <= tcnt_d;
      squash_pend_q <= squash_pend_d;
      err_q         <= err_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  // Saturating performance counters, frozen while halted.
  always_ff @(posedge clk) begin
    if (global_rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (state_q != StHalted) begin
      if (freeze_PC && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (branch_taken_EX && !dmem_stall && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with DMEM_TIMEOUT=8.
// Control outputs are compared as {freeze_PC,FD,DE,EM, clr_FD,DE,MW, halted, mem_timeout_err}.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             global_rst;
  logic [2:0]       rs_FD, rt_FD, write_reg_sel_DE;
  logic             rs_valid_FD, rt_valid_FD, reg_write_en_DE, mem_read_DE;
  logic             branch_taken_EX, imem_stall, dmem_stall, dump_MW;
  logic             freeze_PC, freeze_FD, freeze_DE, freeze_EM;
  logic             clr_FD, clr_DE, clr_MW, halted, mem_timeout_err;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [8:0] NONE = 9'b0000_000_00;
  localparam logic [8:0] LU   = 9'b1100_010_00;
  localparam logic [8:0] BR   = 9'b0000_110_00;
  localparam logic [8:0] IM   = 9'b1000_100_00;
  localparam logic [8:0] DM   = 9'b1111_001_00;
  localparam logic [8:0] HALT = 9'b1111_000_10;
  localparam logic [8:0] TERR = 9'b1111_000_11;

  pipeline_hazard_ctrl #(
    .DMEM_TIMEOUT(8),
    .CNT_W       (CNT_W)
  ) dut (
    .clk             (clk),
    .global_rst      (global_rst),
    .rs_FD           (rs_FD),
    .rs_valid_FD     (rs_valid_FD),
    .rt_FD           (rt_FD),
    .rt_valid_FD     (rt_valid_FD),
    .write_reg_sel_DE(write_reg_sel_DE),
    .reg_write_en_DE (reg_write_en_DE),
    .mem_read_DE     (mem_read_DE),
    .branch_taken_EX (branch_taken_EX),
    .imem_stall      (imem_stall),
    .dmem_stall      (dmem_stall),
    .dump_MW         (dump_MW),
    .freeze_PC       (freeze_PC),
    .freeze_FD       (freeze_FD),
    .freeze_DE       (freeze_DE),
    .freeze_EM       (freeze_EM),
    .clr_FD          (clr_FD),
    .clr_DE          (clr_DE),
    .clr_MW          (clr_MW),
    .halted          (halted),
    .mem_timeout_err (mem_timeout_err),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ctrl();
    return {freeze_PC, freeze_FD, freeze_DE, freeze_EM, clr_FD, clr_DE, clr_MW,
            halted, mem_timeout_err};
  endfunction

  // Check outputs for the inputs currently applied, then advance one clock.
  task automatic cyc(input string tag, input logic [8:0] exp);
    @(negedge clk);
    check(tag, {23'b0, ctrl()}, {23'b0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_FD = 3'd0; rt_FD = 3'd0; write_reg_sel_DE = 3'd0;
    rs_valid_FD = 1'b0; rt_valid_FD = 1'b0; reg_write_en_DE = 1'b0; mem_read_DE = 1'b0;
    branch_taken_EX = 1'b0; imem_stall = 1'b0; dmem_stall = 1'b0; dump_MW = 1'b0;
  endtask

  task automatic set_load_r3();
    mem_read_DE = 1'b1; reg_write_en_DE = 1'b1; write_reg_sel_DE = 3'd3;
  endtask

  initial begin
    idle();
    // reset masks controls even with stall/branch inputs active
    global_rst = 1'b1;
    dmem_stall = 1'b1;
    branch_taken_EX = 1'b1;
    #1;
    cyc("rst_mask0", NONE);
    cyc("rst_mask1", NONE);
    global_rst = 1'b0;
    idle();
    cyc("after_rst", NONE);
    check("stall_cnt_rst", 32'(stall_cycles), 32'd0);
    check("flush_cnt_rst", 32'(flush_count), 32'd0);

    // load-use on rs, then rs not read, then on rt, then bubble gone
    set_load_r3(); rs_FD = 3'd3; rs_valid_FD = 1'b1;
    cyc("lu_rs", LU);
    rs_valid_FD = 1'b0; rt_FD = 3'd5; rt_valid_FD = 1'b1;
    cyc("lu_rs_invalid", NONE);
    rt_FD = 3'd3;
    cyc("lu_rt", LU);
    mem_read_DE = 1'b0;
    cyc("lu_bubble_over", NONE);
    idle();

    // branch outranks load-use
    set_load_r3(); rs_FD = 3'd3; rs_valid_FD = 1'b1; branch_taken_EX = 1'b1;
    cyc("br_over_lu", BR);
    idle();
`ifdef HAZARD_PERF_CNT_EN
    check("flush_cnt_br", 32'(flush_count), 32'd1);
`endif

    // squash: redirect during imem stall, stale fetch dropped when it returns
    branch_taken_EX = 1'b1; imem_stall = 1'b1;
    cyc("sq_branch", BR);
    branch_taken_EX = 1'b0;
    for (int i = 0; i < 3; i++) cyc($sformatf("sq_imem%0d", i), IM);
    imem_stall = 1'b0;
    cyc("sq_release", IM);
    cyc("sq_done", NONE);

    // dmem stall 5 cycles, branch on cycle 2 masked
    dmem_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      branch_taken_EX = (i == 1);
      cyc($sformatf("dm_stall%0d", i), DM);
    end
    idle();
    cyc("dm_release", NONE);
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt", 32'(stall_cycles), 32'd11);
    check("flush_cnt", 32'(flush_count), 32'd2);
`else
    check("stall_cnt_off", 32'(stall_cycles), 32'd0);
    check("flush_cnt_off", 32'(flush_count), 32'd0);
`endif

    // watchdog: 8 stall cycles then halted with sticky error
    dmem_stall = 1'b1;
    for (int i = 0; i < 8; i++) cyc($sformatf("to_stall%0d", i), DM);
    cyc("to_trip", TERR);
    dmem_stall = 1'b0;
    cyc("to_sticky0", TERR);
    branch_taken_EX = 1'b1;
    cyc("to_sticky1", TERR);
    idle();
    global_rst = 1'b1;
    cyc("to_in_rst", 9'b0000_000_11);
    global_rst = 1'b0;
    cyc("to_cleared", NONE);

    // 7 cycles is one short of the limit
    dmem_stall = 1'b1;
    for (int i = 0; i < 7; i++) cyc($sformatf("nt_stall%0d", i), DM);
    dmem_stall = 1'b0;
    cyc("nt_no_err", NONE);

    // halt on dump, hold until reset
    dump_MW = 1'b1;
    cyc("halt_dump", NONE);
    dump_MW = 1'b0;
    cyc("halt0", HALT);
    branch_taken_EX = 1'b1; imem_stall = 1'b1; dmem_stall = 1'b1;
    cyc("halt_hold", HALT);
    idle();
    cyc("halt_hold2", HALT);
    global_rst = 1'b1;
    cyc("halt_in_rst", 9'b0000_000_10);
    global_rst = 1'b0;
    cyc("halt_cleared", NONE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
